// File: rtl/store_data_packer.sv
// store_data_packer: narrows a register value into a lane-aligned memory write with byte enables and req/ack handshake.
// Optional macro STORE_SPLIT_MISALIGNED_EN splits word-crossing stores into two beats.
module store_data_packer #(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic [1:0]        size,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    input  logic              mem_ack,
    output logic              busy,
    output logic              done,
    output logic              err
);
    typedef enum logic [1:0] {IDLE, BEAT1, BEAT2, FIN} state_t;
    localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT + 1) : 1;
    state_t state, next;
    logic [CW-1:0] cnt;
    logic [1:0] off;
    logic [3:0] mask, lo_be, hi_be, hi_be_q;
    logic [31:0] wm, lo_data, hi_data, hi_data_q;
    logic legal, split, split_q, accept, tmo, issue;
    assign off  = addr[1:0];
    assign mask = size == 2'b00 ? 4'b0001 : size == 2'b01 ? 4'b0011 : 4'b1111;
    assign wm   = wdata & {{8{mask[3]}}, {8{mask[2]}}, {8{mask[1]}}, {8{mask[0]}}};
`ifdef STORE_SPLIT_MISALIGNED_EN
    logic [63:0] sh;
    logic [7:0] bsh;
    assign sh      = {32'b0, wm} << {off, 3'b000};
    assign bsh     = {4'b0, mask} << off;
    assign lo_data = sh[31:0];
    assign hi_data = sh[63:32];
    assign lo_be   = bsh[3:0];
    assign hi_be   = bsh[7:4];
    assign split   = |bsh[7:4];
    assign legal   = size != 2'b11;
`else
    assign lo_data = wm << {off, 3'b000};
    assign lo_be   = mask << off;
    assign hi_data = '0;
    assign hi_be   = '0;
    assign split   = 1'b0;
    assign legal   = size == 2'b00 || (size == 2'b01 && !addr[0]) || (size == 2'b10 && off == 2'b00);
`endif
    assign mem_req = state == BEAT1 || state == BEAT2;
    assign busy    = mem_req;
    assign done    = state == FIN;
    assign accept  = start && (state == IDLE || state == FIN);
    assign tmo     = TIMEOUT != 0 && mem_req && !mem_ack && int'(cnt) == TIMEOUT - 1;
    assign issue   = (accept && legal) || (state == BEAT1 && mem_ack && split_q);
    always_comb begin
        next = state;
        case (state)
            IDLE, FIN: next = accept && legal ? BEAT1 : IDLE;
            BEAT1:     next = mem_ack ? (split_q ? BEAT2 : FIN) : tmo ? IDLE : BEAT1;
            BEAT2:     next = mem_ack ? FIN : tmo ? IDLE : BEAT2;
            default:   next = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            err       <= 1'b0;
            cnt       <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            hi_data_q <= '0;
            hi_be_q   <= '0;
            split_q   <= 1'b0;
        end else begin
            state <= next;
            err   <= (accept && !legal) || tmo;
            cnt   <= issue ? '0 : (mem_req && !mem_ack) ? cnt + CW'(1) : cnt;
            if (accept && legal) begin
                mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
                mem_wdata <= lo_data;
                mem_be    <= lo_be;
                hi_data_q <= hi_data;
                hi_be_q   <= hi_be;
                split_q   <= split;
            end else if (state == BEAT1 && mem_ack && split_q) begin
                // second beat: next word up, spill-over lanes
                mem_addr  <= mem_addr + ADDR_W'(4);
                mem_wdata <= hi_data_q;
                mem_be    <= hi_be_q;
            end
        end
    end
endmodule

// File: tb/tb_store_data_packer.sv
// tb_store_data_packer: table-driven single-beat vectors plus hand sequences for wait, timeout, reset and back-to-back.
module tb_store_data_packer;
    logic clk = 0, rst = 1, start = 0, mem_ack = 0;
    logic [31:0] addr = 0, wdata = 0, mem_addr, mem_wdata;
    logic [1:0] size = 0;
    logic [3:0] mem_be;
    logic mem_req, busy, done, err;
    int n_chk = 0, n_fail = 0, done_cnt = 0;

    store_data_packer #(.ADDR_W(32), .TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .start(start), .addr(addr), .wdata(wdata), .size(size),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_ack(mem_ack), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
        logic [1:0]  s;
        logic        e;
        logic [31:0] ea;
        logic [31:0] ed;
        logic [3:0]  eb;
    } vec_t;
    vec_t v [12];
    int nv;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done) done_cnt++;
        if (!rst) chk("done_err_excl", {31'b0, done & err}, 0);
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        @(negedge clk);
        start = 1; addr = a; wdata = d; size = s;
        @(negedge clk);
        start = 0;
    endtask

    task automatic run_vec(input vec_t x);
        issue(x.a, x.d, x.s);
        if (x.e) begin
            chk("vec_err", {31'b0, err}, 1);
            chk("vec_err_noreq", {31'b0, mem_req}, 0);
            @(negedge clk);
            chk("vec_err_pulse", {31'b0, err}, 0);
        end else begin
            chk("vec_req", {31'b0, mem_req}, 1);
            chk("vec_busy", {31'b0, busy}, 1);
            chk("vec_addr", mem_addr, x.ea);
            chk("vec_wdata", mem_wdata, x.ed);
            chk("vec_be", {28'b0, mem_be}, {28'b0, x.eb});
            mem_ack = 1;
            @(negedge clk);
            mem_ack = 0;
            chk("vec_done", {31'b0, done}, 1);
            chk("vec_fin_req", {31'b0, mem_req}, 0);
            chk("vec_fin_busy", {31'b0, busy}, 0);
            @(negedge clk);
            chk("vec_done_pulse", {31'b0, done}, 0);
        end
    endtask

    initial begin
        nv = 0;
        v[nv++] = '{32'h1003, 32'hAABBCCDD, 2'b00, 1'b0, 32'h1000, 32'hDD000000, 4'b1000};
        v[nv++] = '{32'h1000, 32'hAABBCCDD, 2'b00, 1'b0, 32'h1000, 32'h000000DD, 4'b0001};
        v[nv++] = '{32'h1001, 32'hAABBCCDD, 2'b00, 1'b0, 32'h1000, 32'h0000DD00, 4'b0010};
        v[nv++] = '{32'h2002, 32'h12345678, 2'b01, 1'b0, 32'h2000, 32'h56780000, 4'b1100};
        v[nv++] = '{32'h2000, 32'h12345678, 2'b01, 1'b0, 32'h2000, 32'h00005678, 4'b0011};
        v[nv++] = '{32'h3000, 32'h12345678, 2'b10, 1'b0, 32'h3000, 32'h12345678, 4'b1111};
        v[nv++] = '{32'h4000, 32'h12345678, 2'b11, 1'b1, 32'h0, 32'h0, 4'b0};
`ifdef STORE_SPLIT_MISALIGNED_EN
        v[nv++] = '{32'h2001, 32'h12345678, 2'b01, 1'b0, 32'h2000, 32'h00567800, 4'b0110};
`else
        v[nv++] = '{32'h2001, 32'h12345678, 2'b01, 1'b1, 32'h0, 32'h0, 4'b0};
        v[nv++] = '{32'h2003, 32'h12345678, 2'b01, 1'b1, 32'h0, 32'h0, 4'b0};
        v[nv++] = '{32'h3002, 32'h12345678, 2'b10, 1'b1, 32'h0, 32'h0, 4'b0};
        v[nv++] = '{32'h3003, 32'h12345678, 2'b10, 1'b1, 32'h0, 32'h0, 4'b0};
`endif
        repeat (3) @(negedge clk);
        chk("rst_req", {31'b0, mem_req}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_done", {31'b0, done}, 0);
        chk("rst_err", {31'b0, err}, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_be", {28'b0, mem_be}, 0);
        rst = 0;
        for (int i = 0; i < nv; i++) run_vec(v[i]);

        // half store with ack delayed 3 cycles: values held for 4 cycles
        issue(32'h2002, 32'h12345678, 2'b01);
        for (int i = 0; i < 4; i++) begin
            chk("wait_req", {31'b0, mem_req}, 1);
            chk("wait_addr", mem_addr, 32'h2000);
            chk("wait_wdata", mem_wdata, 32'h56780000);
            chk("wait_be", {28'b0, mem_be}, {28'b0, 4'b1100});
            chk("wait_nodone", {31'b0, done}, 0);
            mem_ack = i == 3;
            @(negedge clk);
        end
        mem_ack = 0;
        chk("wait_done", {31'b0, done}, 1);
        @(negedge clk);

        // misaligned word
        issue(32'h3001, 32'hCAFEF00D, 2'b10);
`ifdef STORE_SPLIT_MISALIGNED_EN
        chk("split_b1_addr", mem_addr, 32'h3000);
        chk("split_b1_be", {28'b0, mem_be}, {28'b0, 4'b1110});
        chk("split_b1_wdata", mem_wdata, 32'hFEF00D00);
        mem_ack = 1;
        @(negedge clk);
        chk("split_b2_req", {31'b0, mem_req}, 1);
        chk("split_b2_addr", mem_addr, 32'h3004);
        chk("split_b2_be", {28'b0, mem_be}, {28'b0, 4'b0001});
        chk("split_b2_wdata", mem_wdata, 32'h000000CA);
        chk("split_b2_nodone", {31'b0, done}, 0);
        @(negedge clk);
        mem_ack = 0;
        chk("split_done", {31'b0, done}, 1);
`else
        chk("mis_err", {31'b0, err}, 1);
        chk("mis_noreq", {31'b0, mem_req}, 0);
        @(negedge clk);
        chk("mis_noreq2", {31'b0, mem_req}, 0);
        chk("mis_err_pulse", {31'b0, err}, 0);
`endif
        @(negedge clk);

        // timeout: req high exactly 4 cycles, then err
        issue(32'h1000, 32'h1, 2'b10);
        for (int i = 0; i < 4; i++) begin
            chk("tmo_req", {31'b0, mem_req}, 1);
            @(negedge clk);
        end
        chk("tmo_req_drop", {31'b0, mem_req}, 0);
        chk("tmo_err", {31'b0, err}, 1);
        chk("tmo_busy", {31'b0, busy}, 0);
        chk("tmo_nodone", {31'b0, done}, 0);
        @(negedge clk);

        // reset mid-BEAT1, then a fresh store
        issue(32'h8000, 32'h5, 2'b00);
        @(negedge clk);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("rstmid_req", {31'b0, mem_req}, 0);
        chk("rstmid_busy", {31'b0, busy}, 0);
        chk("rstmid_done", {31'b0, done}, 0);
        chk("rstmid_err", {31'b0, err}, 0);
        run_vec('{32'h9002, 32'h000000EE, 2'b00, 1'b0, 32'h9000, 32'h00EE0000, 4'b0100});

        // back-to-back: busy-time start ignored, FIN-cycle start accepted
        done_cnt = 0;
        issue(32'h5000, 32'h11111111, 2'b10);
        start = 1; addr = 32'h7000; wdata = 32'h33333333; mem_ack = 1;
        chk("b2b_a_addr", mem_addr, 32'h5000);
        @(negedge clk);
        chk("b2b_a_done", {31'b0, done}, 1);
        addr = 32'h6000; wdata = 32'h22222222; mem_ack = 0;
        @(negedge clk);
        start = 0;
        chk("b2b_b_req", {31'b0, mem_req}, 1);
        chk("b2b_b_addr", mem_addr, 32'h6000);
        chk("b2b_b_wdata", mem_wdata, 32'h22222222);
        mem_ack = 1;
        @(negedge clk);
        mem_ack = 0;
        chk("b2b_b_done", {31'b0, done}, 1);
        repeat (4) @(negedge clk);
        chk("b2b_done_count", done_cnt, 2);
        chk("b2b_idle_req", {31'b0, mem_req}, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
